// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the IO responder slice.
//   idx_w()       port-index width helper (clog2 with a floor of 1 bit),
//                 used for both the input (NUIOIN) and output (NUIOOU) index.
//   io_entry_t    output FIFO entry {addr, data} at the default geometry
//                 (8 output ports, 32-bit data); io_responder declares the
//                 same shape at its own parameters and hands it to io_fifo.
//   IO_OVF_CNT_W  width of the optional overflow counter.
package io_pkg;

  localparam int IO_OVF_CNT_W   = 8;
  localparam int IO_NUBITS_DFLT = 32;
  localparam int IO_NUIOOU_DFLT = 8;

  // Index width for a bank of n ports; a single port still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [idx_w(IO_NUIOOU_DFLT)-1:0] addr;
    logic [IO_NUBITS_DFLT-1:0]        data;
  } io_entry_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: registered output FIFO, no write-to-read bypass.
//   clk, rst  clock, asynchronous active-high reset (pointers and count)
//   push, din write request and entry
//   pop       read request (ignored when empty)
//   head      entry at the read pointer
//   full, empty, count  occupancy, count in 0..FDEPTH
// A push into a full FIFO is accepted only when a pop happens on the same
// edge. FDEPTH must be a power of two >= 2 so the pointers wrap naturally.
module io_fifo
  import io_pkg::*;
#(
  parameter int  FDEPTH  = 4,
  parameter type entry_t = io_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  entry_t                       din,
  input  logic                         pop,
  output entry_t                       head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FDEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = $clog2(FDEPTH + 1);

  entry_t          mem_q [FDEPTH];
  entry_t          mem_d [FDEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CW'(FDEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: it is only observed through entries counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/io_responder.sv
// io_responder: core-facing IO block with latched inputs and queued outputs.
//   clk, rst        clock, asynchronous active-high reset
//   req_in, addr_in core read strobe / port index; io_in is in_reg[addr_in]
//                   combinationally, req_in only clears in_fresh
//   out_en, addr_out, data_out  core write; updates out_regs and queues
//                   {addr,data} into the output FIFO
//   ext_in, ext_in_vld, in_fresh  peripheral inputs, load strobes, unread flags
//   ext_out_*       FIFO head towards the peripheral
//   out_regs        last value written per output port
//   ovf, ovf_clr    sticky flag for writes dropped because the FIFO was full
//   ovf_cnt         saturating drop counter, present only with IO_OVF_CNT_EN
// Handshake: ext_out_vld is high whenever the FIFO holds an entry and the
// head (data, addr) is held stable until an edge with ext_out_vld and
// ext_out_rdy both high, which transfers it; vld never waits on rdy.
// Out-of-range port indices read as 0 and writes to them are discarded.
module io_responder
  import io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_in,
  input  logic [idx_w(NUIOIN)-1:0]     addr_in,
  output logic [NUBITS-1:0]            io_in,
  input  logic                         out_en,
  input  logic [idx_w(NUIOOU)-1:0]     addr_out,
  input  logic [NUBITS-1:0]            data_out,
  input  logic [NUIOIN*NUBITS-1:0]     ext_in,
  input  logic [NUIOIN-1:0]            ext_in_vld,
  output logic [NUIOIN-1:0]            in_fresh,
  output logic [NUBITS-1:0]            ext_out_data,
  output logic [idx_w(NUIOOU)-1:0]     ext_out_addr,
  output logic                         ext_out_vld,
  input  logic                         ext_out_rdy,
  output logic [NUIOOU*NUBITS-1:0]     out_regs,
  output logic                         ovf,
`ifdef IO_OVF_CNT_EN
  output logic [IO_OVF_CNT_W-1:0]      ovf_cnt,
`endif
  input  logic                         ovf_clr
);

  localparam int OAW = idx_w(NUIOOU);
  localparam int CW  = $clog2(FDEPTH + 1);

  typedef struct packed {
    logic [OAW-1:0]    addr;
    logic [NUBITS-1:0] data;
  } entry_t;

  logic [NUBITS-1:0] in_reg_q  [NUIOIN];
  logic [NUBITS-1:0] in_reg_d  [NUIOIN];
  logic [NUIOIN-1:0] fresh_q, fresh_d;
  logic [NUBITS-1:0] out_q     [NUIOOU];
  logic [NUBITS-1:0] out_d     [NUIOOU];
  logic              ovf_q, ovf_d;

  logic              rd_ok, wr_ok, push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  entry_t            fifo_din, fifo_head;

  assign rd_ok = (32'(addr_in) < 32'(NUIOIN));
  assign wr_ok = (32'(addr_out) < 32'(NUIOOU));
  assign push  = out_en & wr_ok;
  assign pop   = ext_out_vld & ext_out_rdy;
  // A full FIFO only makes room when the head leaves on this same edge.
  assign drop  = push & fifo_full & ~pop;

  assign fifo_din.addr = addr_out;
  assign fifo_din.data = data_out;

  io_fifo #(
    .FDEPTH  (FDEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign io_in        = rd_ok ? in_reg_q[addr_in] : '0;
  assign in_fresh     = fresh_q;
  assign ext_out_vld  = (fifo_count != '0);
  // Head fields are forced to zero while empty so stale storage never shows.
  assign ext_out_data = fifo_empty ? '0 : fifo_head.data;
  assign ext_out_addr = fifo_empty ? '0 : fifo_head.addr;
  assign ovf          = ovf_q;

  for (genvar g = 0; g < NUIOOU; g++) begin : g_out_regs
    assign out_regs[g*NUBITS +: NUBITS] = out_q[g];
  end

  always_comb begin
    in_reg_d = in_reg_q;
    fresh_d  = fresh_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < NUIOIN; i++) begin
      // A load wins over a same-edge read: io_in showed the old value this
      // cycle, so the new one is still unread.
      if (ext_in_vld[i]) begin
        in_reg_d[i] = ext_in[i*NUBITS +: NUBITS];
        fresh_d[i]  = 1'b1;
      end else if (req_in && rd_ok && (32'(addr_in) == 32'(i))) begin
        fresh_d[i]  = 1'b0;
      end
    end
    if (push) begin
      out_d[addr_out] = data_out;
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUIOIN; i++) in_reg_q[i] <= '0;
      for (int i = 0; i < NUIOOU; i++) out_q[i]    <= '0;
      fresh_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      in_reg_q <= in_reg_d;
      out_q    <= out_d;
      fresh_q  <= fresh_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef IO_OVF_CNT_EN
  logic [IO_OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  assign ovf_cnt = ovf_cnt_q;

  // Clear restarts the count, so a drop on the clearing edge leaves 1.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = drop ? IO_OVF_CNT_W'(1) : '0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + IO_OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end
`endif

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed bench for io_responder (6 input ports, 7 output
// ports so that index 7 is out of range on both sides, 32-bit data, depth 4).
// Optional checks of ovf_cnt are compiled in with IO_OVF_CNT_EN.
module tb_io_responder;
  localparam int NB = 32;
  localparam int NI = 6;
  localparam int NO = 7;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_in = 1'b0;
  logic [2:0]        addr_in = '0;
  logic [NB-1:0]     io_in;
  logic              out_en = 1'b0;
  logic [2:0]        addr_out = '0;
  logic [NB-1:0]     data_out = '0;
  logic [NI*NB-1:0]  ext_in = '0;
  logic [NI-1:0]     ext_in_vld = '0;
  logic [NI-1:0]     in_fresh;
  logic [NB-1:0]     ext_out_data;
  logic [2:0]        ext_out_addr;
  logic              ext_out_vld;
  logic              ext_out_rdy = 1'b0;
  logic [NO*NB-1:0]  out_regs;
  logic              ovf;
  logic              ovf_clr = 1'b0;
`ifdef IO_OVF_CNT_EN
  logic [7:0]        ovf_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected FIFO contents {addr,data} and expected out_regs.
  logic [NB+2:0]     exp_q[$];
  logic [NB+2:0]     exp_head;
  logic [NO*NB-1:0]  exp_out = '0;

  io_responder #(
    .NUBITS (NB),
    .NUIOIN (NI),
    .NUIOOU (NO),
    .FDEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_in       (req_in),
    .addr_in      (addr_in),
    .io_in        (io_in),
    .out_en       (out_en),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .ext_in       (ext_in),
    .ext_in_vld   (ext_in_vld),
    .in_fresh     (in_fresh),
    .ext_out_data (ext_out_data),
    .ext_out_addr (ext_out_addr),
    .ext_out_vld  (ext_out_vld),
    .ext_out_rdy  (ext_out_rdy),
    .out_regs     (out_regs),
    .ovf          (ovf),
`ifdef IO_OVF_CNT_EN
    .ovf_cnt      (ovf_cnt),
`endif
    .ovf_clr      (ovf_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  // One core write with ext_out_rdy low; updates the expected model.
  task automatic write_out(input logic [2:0] a, input logic [NB-1:0] d);
    out_en   = 1'b1;
    addr_out = a;
    data_out = d;
    if (int'(a) < NO) begin
      exp_out[int'(a)*NB +: NB] = d;
      if (exp_q.size() < FD) exp_q.push_back({a, d});
    end
    step();
    out_en = 1'b0;
  endtask

  task automatic load_in(input int p, input logic [NB-1:0] d);
    ext_in[p*NB +: NB] = d;
    ext_in_vld         = '0;
    ext_in_vld[p]      = 1'b1;
    step();
    ext_in_vld = '0;
  endtask

  // Drain with rdy high, comparing each head to the scoreboard per cycle.
  task automatic drain(input string tag);
    ext_out_rdy = 1'b1;
    for (int n = 0; n < FD + 1 && exp_q.size() > 0; n++) begin
      exp_head = exp_q.pop_front();
      total++;
      if (!ext_out_vld || {ext_out_addr, ext_out_data} !== exp_head) begin
        bad++;
        $display("FAIL %s_head%0d: got vld=%b {%0d,%0d} want vld=1 {%0d,%0d}", tag, n,
                 ext_out_vld, ext_out_addr, ext_out_data, exp_head[NB+2:NB], exp_head[NB-1:0]);
      end
      step();
    end
    ext_out_rdy = 1'b0;
    total++;
    if (ext_out_vld !== 1'b0 || ext_out_data !== '0) begin
      bad++;
      $display("FAIL %s_empty: got vld=%b data=%h want vld=0 data=0", tag, ext_out_vld, ext_out_data);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++;
    if (io_in !== '0 || ext_out_vld !== 1'b0 || ext_out_data !== '0 || ext_out_addr !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got io_in=%h vld=%b data=%h addr=%0d want all 0",
               io_in, ext_out_vld, ext_out_data, ext_out_addr);
    end
    total++;
    if (in_fresh !== '0 || out_regs !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got fresh=%b out_regs=%h ovf=%b want 0", in_fresh, out_regs, ovf);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_input();
    load_in(3, 32'hA5A5_0001);
    total++;
    if (in_fresh !== 6'b001000) begin
      bad++;
      $display("FAIL in_fresh_set: got %b want %b", in_fresh, 6'b001000);
    end
    addr_in = 3'd3;
    #1;
    total++;
    if (io_in !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL io_in_read: got %h want %h", io_in, 32'hA5A5_0001);
    end
    req_in = 1'b1;
    step();
    req_in = 1'b0;
    total++;
    if (in_fresh[3] !== 1'b0) begin
      bad++;
      $display("FAIL in_fresh_clear: got %b want 0", in_fresh[3]);
    end
    addr_in = 3'd7;
    #1;
    total++;
    if (io_in !== '0) begin
      bad++;
      $display("FAIL io_in_oob: got %h want 0", io_in);
    end
    addr_in = 3'd0;
  endtask

  task automatic test_load_read();
    load_in(2, 32'd5);
    addr_in = 3'd2;
    req_in  = 1'b1;
    step();
    total++;
    if (in_fresh[2] !== 1'b0) begin
      bad++;
      $display("FAIL lr_pre_clear: got %b want 0", in_fresh[2]);
    end
    ext_in[2*NB +: NB] = 32'd9;
    ext_in_vld         = 6'b000100;
    #1;
    total++;
    if (io_in !== 32'd5) begin
      bad++;
      $display("FAIL lr_old_value: got %0d want 5", io_in);
    end
    step();
    ext_in_vld = '0;
    req_in     = 1'b0;
    total++;
    if (io_in !== 32'd9 || in_fresh[2] !== 1'b1) begin
      bad++;
      $display("FAIL lr_new_value: got io_in=%0d fresh=%b want 9 1", io_in, in_fresh[2]);
    end
  endtask

  task automatic test_fifo_fill();
    ext_out_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) write_out(3'(k), NB'(10 * k));
    total++;
    if (dut.fifo_count !== 3'd4 || ext_out_vld !== 1'b1 || ext_out_addr !== 3'd1 ||
        ext_out_data !== 32'd10 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL fill_full: got count=%0d vld=%b head={%0d,%0d} ovf=%b want 4 1 {1,10} 0",
               dut.fifo_count, ext_out_vld, ext_out_addr, ext_out_data, ovf);
    end
    write_out(3'd5, 32'd50);
    total++;
    if (out_regs !== exp_out || out_regs[5*NB +: NB] !== 32'd50 || ovf !== 1'b1 ||
        dut.fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fill_drop: got out5=%0d ovf=%b count=%0d want 50 1 4",
               out_regs[5*NB +: NB], ovf, dut.fifo_count);
    end
    drain("fill");
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL fill_ovf_clr: got %b want 0", ovf);
    end
  endtask

  task automatic test_full_pop();
    for (int k = 1; k <= 4; k++) write_out(3'(k), NB'(10 * k));
    ext_out_rdy = 1'b1;
    out_en      = 1'b1;
    addr_out    = 3'd6;
    data_out    = 32'd60;
    void'(exp_q.pop_front());
    exp_q.push_back({3'd6, 32'd60});
    exp_out[6*NB +: NB] = 32'd60;
    step();
    out_en      = 1'b0;
    ext_out_rdy = 1'b0;
    total++;
    if (ovf !== 1'b0 || dut.fifo_count !== 3'd4 || out_regs !== exp_out ||
        ext_out_addr !== 3'd2 || ext_out_data !== 32'd20) begin
      bad++;
      $display("FAIL full_pop: got ovf=%b count=%0d head={%0d,%0d} want 0 4 {2,20}",
               ovf, dut.fifo_count, ext_out_addr, ext_out_data);
    end
    drain("fullpop");
  endtask

  task automatic test_oob_write();
    write_out(3'd7, 32'hDEAD_BEEF);
    total++;
    if (out_regs !== exp_out || ext_out_vld !== 1'b0 || dut.fifo_count !== 3'd0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL oob_write: got out_regs=%h vld=%b count=%0d want %h 0 0",
               out_regs, ext_out_vld, dut.fifo_count, exp_out);
    end
  endtask

  task automatic test_ovf();
    for (int k = 1; k <= 4; k++) write_out(3'(k), NB'(100 + k));
    ovf_clr = 1'b1;
    write_out(3'd1, 32'd1);
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_wins: got %b want 1", ovf);
    end
`ifdef IO_OVF_CNT_EN
    total++;
    if (ovf_cnt !== 8'd1) begin
      bad++;
      $display("FAIL ovf_cnt_clr_drop: got %0d want 1", ovf_cnt);
    end
`endif
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr_alone: got %b want 0", ovf);
    end
`ifdef IO_OVF_CNT_EN
    for (int n = 0; n < 300; n++) write_out(3'd1, NB'(n));
    total++;
    if (ovf_cnt !== 8'd255 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_cnt_sat: got cnt=%0d ovf=%b want 255 1", ovf_cnt, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    // FIFO is full from test_ovf: drop once, pop once -> 3 pending, ovf=1.
    write_out(3'd2, 32'h222);
    ext_out_rdy = 1'b1;
    step();
    ext_out_rdy = 1'b0;
    void'(exp_q.pop_front());
    load_in(4, 32'h4444);
    total++;
    if (dut.fifo_count !== 3'd3 || ovf !== 1'b1 || in_fresh[4] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got count=%0d ovf=%b fresh4=%b want 3 1 1",
               dut.fifo_count, ovf, in_fresh[4]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ext_out_vld !== 1'b0 || dut.fifo_count !== 3'd0 || ext_out_data !== '0 ||
        out_regs !== '0 || in_fresh !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async: got vld=%b count=%0d out_regs=%h fresh=%b ovf=%b want all 0",
               ext_out_vld, dut.fifo_count, out_regs, in_fresh, ovf);
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_out = '0;
    step();
    total++;
    if (ext_out_vld !== 1'b0 || io_in !== '0) begin
      bad++;
      $display("FAIL rstmid_after: got vld=%b io_in=%h want 0 0", ext_out_vld, io_in);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_input();
    test_load_read();
    test_fifo_fill();
    test_full_pop();
    test_oob_write();
    test_ovf();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always ends even if a task stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
